// File: rtl/nnrv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nnrv_mem_pkg
// Description : Shared definitions for the nnrv RAM arbiter, the RAM and
//               nnrv_top: owner encoding, response tag, RAM geometry defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package nnrv_mem_pkg;

    // Requester that owns an in-flight response
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // RAM geometry defaults shared with nnrv_top and the RAM itself
    localparam int          RAM_AW_DEFAULT    = 10;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;

    // Tag carried alongside a granted access to steer its response
    typedef struct packed {
        logic owner;     // OWN_IFU / OWN_LSU
        logic is_err;    // access was outside the RAM window
        logic is_write;  // LSU write: response carries no data
    } rsp_tag_t;

    localparam int RSP_TAG_W = $bits(rsp_tag_t);

endpackage
`default_nettype wire

// File: rtl/nnrv_mem_arb_starve.sv
`default_nettype none
// ============================================================================
// Module      : nnrv_mem_arb_starve
// Description : Two-way priority select (LSU first) with a saturating IFU
//               starvation counter that hands the IFU the next contested slot.
// Revision    : 1.0 - initial release
// ============================================================================
module nnrv_mem_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ifu_req,
    input  logic i_lsu_req,
    output logic o_ifu_gnt,
    output logic o_lsu_gnt
);

    localparam int              CW           = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   c_starve_max = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;
    logic          w_starved;

    assign w_starved = (r_cnt == c_starve_max);

    // Priority select: LSU wins contention unless the IFU has waited long enough
    always_comb begin
        o_ifu_gnt = 1'b0;
        o_lsu_gnt = 1'b0;
        if (!i_rst) begin
            if (i_lsu_req && !(i_ifu_req && w_starved)) begin
                o_lsu_gnt = 1'b1;
            end else if (i_ifu_req) begin
                o_ifu_gnt = 1'b1;
            end
        end
    end

    // Count consecutive denied IFU cycles, saturating; clear on grant or idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_ifu_req && !o_ifu_gnt) begin
            if (!w_starved) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nnrv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : nnrv_mem_arb
// Description : Shares one single-port synchronous RAM between IFU and LSU.
//               One grant per cycle, address window check, and a tagged
//               one-cycle response path back to the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module nnrv_mem_arb
    import nnrv_mem_pkg::*;
#(
    parameter int          RAM_AW     = RAM_AW_DEFAULT,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ifu_req,
    input  logic [31:0]       i_ifu_addr,
    output logic              o_ifu_gnt,
    output logic              o_ifu_rvalid,
    output logic [31:0]       o_ifu_rdata,
    output logic              o_ifu_err,
    input  logic              i_lsu_req,
    input  logic              i_lsu_we,
    input  logic [31:0]       i_lsu_addr,
    input  logic [31:0]       i_lsu_wdata,
    input  logic [3:0]        i_lsu_wstrb,
    output logic              o_lsu_gnt,
    output logic              o_lsu_rvalid,
    output logic [31:0]       o_lsu_rdata,
    output logic              o_lsu_err,
    output logic              o_ram_en,
    output logic [3:0]        o_ram_we,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    // Size of the RAM window in bytes, held at 33 bits so the compare below
    // also rejects addresses beneath BASE_ADDR (they wrap to bit 32 set).
    localparam logic [32:0] c_ram_bytes = 33'(1) << (RAM_AW + 2);

    logic        w_ifu_gnt;
    logic        w_lsu_gnt;
    logic        w_any_gnt;
    logic [31:0] w_addr;
    logic [32:0] w_off;
    logic        w_in_range;
    logic        w_is_write;
    logic [31:0] w_rdata;
    rsp_tag_t    w_tag;

    logic        r_rvalid;
    rsp_tag_t    r_tag;

    nnrv_mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ifu_req (i_ifu_req),
        .i_lsu_req (i_lsu_req),
        .o_ifu_gnt (w_ifu_gnt),
        .o_lsu_gnt (w_lsu_gnt)
    );

    assign o_ifu_gnt  = w_ifu_gnt;
    assign o_lsu_gnt  = w_lsu_gnt;
    assign w_any_gnt  = w_ifu_gnt | w_lsu_gnt;

    // Decode the winner's address into a RAM word index and window check
    assign w_addr     = w_lsu_gnt ? i_lsu_addr : i_ifu_addr;
    assign w_off      = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_in_range = (w_off < c_ram_bytes);
    assign w_is_write = w_lsu_gnt & i_lsu_we;

    // RAM drive: out-of-range grants still complete but never touch the RAM
    assign o_ram_en    = w_any_gnt & w_in_range;
    assign o_ram_we    = (w_is_write && w_in_range) ? i_lsu_wstrb : 4'b0000;
    assign o_ram_addr  = w_off[RAM_AW+1:2];
    assign o_ram_wdata = i_lsu_wdata;

    assign w_tag.owner    = w_lsu_gnt ? OWN_LSU : OWN_IFU;
    assign w_tag.is_err   = ~w_in_range;
    assign w_tag.is_write = w_is_write;

    // Response pipeline: one valid + tag per grant, dropped by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid <= 1'b0;
            r_tag    <= '0;
        end else begin
            r_rvalid <= w_any_gnt;
            r_tag    <= w_tag;
        end
    end

    // Only in-range reads return RAM data; writes and errors return zero
    assign w_rdata = (r_tag.is_err || r_tag.is_write) ? 32'h0 : i_ram_rdata;

    assign o_ifu_rvalid = r_rvalid & (r_tag.owner == OWN_IFU);
    assign o_lsu_rvalid = r_rvalid & (r_tag.owner == OWN_LSU);
    assign o_ifu_rdata  = o_ifu_rvalid ? w_rdata : 32'h0;
    assign o_lsu_rdata  = o_lsu_rvalid ? w_rdata : 32'h0;
    assign o_ifu_err    = o_ifu_rvalid & r_tag.is_err;
    assign o_lsu_err    = o_lsu_rvalid & r_tag.is_err;

endmodule
`default_nettype wire

// File: tb/tb_nnrv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_nnrv_mem_arb
// Description : Self-checking bench for nnrv_mem_arb with a behavioural RAM,
//               an arbitration/address model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nnrv_mem_arb;

    localparam int          RAM_AW     = 10;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
    localparam int          DEPTH      = 1 << RAM_AW;

    logic              clk;
    logic              rst;
    logic              ifu_req;
    logic [31:0]       ifu_addr;
    logic              ifu_gnt, ifu_rvalid, ifu_err;
    logic [31:0]       ifu_rdata;
    logic              lsu_req, lsu_we;
    logic [31:0]       lsu_addr, lsu_wdata;
    logic [3:0]        lsu_wstrb;
    logic              lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0]       lsu_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    nnrv_mem_arb #(
        .RAM_AW     (RAM_AW),
        .STARVE_MAX (STARVE_MAX),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ifu_req    (ifu_req),
        .i_ifu_addr   (ifu_addr),
        .o_ifu_gnt    (ifu_gnt),
        .o_ifu_rvalid (ifu_rvalid),
        .o_ifu_rdata  (ifu_rdata),
        .o_ifu_err    (ifu_err),
        .i_lsu_req    (lsu_req),
        .i_lsu_we     (lsu_we),
        .i_lsu_addr   (lsu_addr),
        .i_lsu_wdata  (lsu_wdata),
        .i_lsu_wstrb  (lsu_wstrb),
        .o_lsu_gnt    (lsu_gnt),
        .o_lsu_rvalid (lsu_rvalid),
        .o_lsu_rdata  (lsu_rdata),
        .o_lsu_err    (lsu_err),
        .o_ram_en     (ram_en),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with byte enables and one-cycle read latency
    logic [31:0] ram_mem [DEPTH];
    initial begin
        ram_rdata <= '0;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    typedef struct {
        logic        owner;   // 0 = IFU, 1 = LSU
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] shadow [DEPTH];
    int          m_cnt;
    initial begin
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    end

    // Monitor: check responses against the scoreboard, then model this cycle's grant
    always @(negedge clk) begin
        exp_t        e;
        logic        has;
        logic        eg_ifu, eg_lsu, inr, wr;
        logic [31:0] a;
        logic [32:0] off;
        int          idx;
        logic [3:0]  ewe;

        has = (sb_q.size() > 0);
        if (has) e = sb_q.pop_front();
        check("ifu_rvalid", ifu_rvalid, has && !e.owner);
        check("lsu_rvalid", lsu_rvalid, has && e.owner);
        if (has && !e.owner) begin
            check("ifu_err",   ifu_err,   e.err);
            check("ifu_rdata", ifu_rdata, e.rdata);
        end
        if (has && e.owner) begin
            check("lsu_err",   lsu_err,   e.err);
            check("lsu_rdata", lsu_rdata, e.rdata);
        end

        eg_ifu = 1'b0;
        eg_lsu = 1'b0;
        if (!rst) begin
            if (lsu_req && ifu_req) begin
                if (m_cnt == STARVE_MAX) eg_ifu = 1'b1;
                else                     eg_lsu = 1'b1;
            end else begin
                eg_lsu = lsu_req;
                eg_ifu = ifu_req;
            end
        end
        check("ifu_gnt", ifu_gnt, eg_ifu);
        check("lsu_gnt", lsu_gnt, eg_lsu);

        if (eg_ifu || eg_lsu) begin
            a   = eg_lsu ? lsu_addr : ifu_addr;
            off = {1'b0, a} - {1'b0, BASE_ADDR};
            inr = (off < 33'(4 * DEPTH));
            idx = int'(off[RAM_AW+1:2]);
            wr  = eg_lsu && lsu_we;
            ewe = (wr && inr) ? lsu_wstrb : 4'b0000;
            check("ram_en", ram_en, inr);
            check("ram_we", ram_we, ewe);
            if (inr) check("ram_addr", ram_addr, idx[RAM_AW-1:0]);
            if (wr && inr) check("ram_wdata", ram_wdata, lsu_wdata);
            e.owner = eg_lsu;
            e.err   = !inr;
            e.rdata = (!wr && inr) ? shadow[idx] : 32'h0;
            if (wr && inr)
                for (int b = 0; b < 4; b++)
                    if (lsu_wstrb[b]) shadow[idx][8*b +: 8] = lsu_wdata[8*b +: 8];
            sb_q.push_back(e);
        end else begin
            check("idle_ram_en", ram_en, 1'b0);
            check("idle_ram_we", ram_we, 4'b0000);
        end

        if (rst || !ifu_req || eg_ifu) m_cnt = 0;
        else if (m_cnt < STARVE_MAX)   m_cnt++;
        if (rst) sb_q.delete();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifu_req   = 1'b0;
        lsu_req   = 1'b0;
        lsu_we    = 1'b0;
        lsu_wstrb = 4'b0000;
    endtask

    task automatic lsu_op(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        lsu_req   = 1'b1;
        lsu_we    = we;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_wstrb = strb;
        step();
        idle();
    endtask

    logic [9:0] pat;

    initial begin
        rst       = 1'b1;
        ifu_addr  = '0;
        lsu_addr  = '0;
        lsu_wdata = '0;
        idle();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Preload through the LSU path
        lsu_op(1'b1, 32'h0C, 32'hDEADBEEF, 4'b1111);
        lsu_op(1'b1, 32'h10, 32'hAABBCCDD, 4'b1111);
        step();

        // Solo IFU read of word 3
        ifu_req  = 1'b1;
        ifu_addr = 32'h0C;
        step();
        idle();
        #2 check("ifu_read_deadbeef", ifu_rdata, 32'hDEADBEEF);
        step();

        // Partial write then read-back
        lsu_op(1'b1, 32'h10, 32'h11223344, 4'b0011);
        lsu_op(1'b0, 32'h10, 32'h0, 4'b0000);
        #2 check("lsu_merge_read", lsu_rdata, 32'hAABB3344);
        // Zero-strobe write changes nothing but still responds
        lsu_op(1'b1, 32'h12, 32'hFFFFFFFF, 4'b0000);
        lsu_op(1'b0, 32'h10, 32'h0, 4'b0000);
        #2 check("lsu_zero_strobe", lsu_rdata, 32'hAABB3344);

        // Range boundary
        lsu_op(1'b0, 32'h1000, 32'h0, 4'b0000);
        #2 check("oor_err", lsu_err, 1'b1);
        lsu_op(1'b1, 32'h0FFC, 32'hCAFEF00D, 4'b1111);
        lsu_op(1'b0, 32'h0FFC, 32'h0, 4'b0000);
        #2 check("top_word_read", lsu_rdata, 32'hCAFEF00D);
        lsu_op(1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'b1111);
        ifu_req  = 1'b1;
        ifu_addr = 32'h0000_2000;
        step();
        idle();
        step();

        // Reset in the cycle of an IFU request
        ifu_req  = 1'b1;
        ifu_addr = 32'h0C;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #2 check("no_rvalid_after_rst", ifu_rvalid, 1'b0);
        step();

        // Continuous contention: IFU wins every fifth slot
        ifu_req  = 1'b1;
        ifu_addr = 32'h0C;
        lsu_req  = 1'b1;
        lsu_we   = 1'b0;
        lsu_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            #2 pat[i] = ifu_gnt;
            step();
        end
        idle();
        check("contend_pattern", pat, 10'b10_0001_0000);
        step();

        // Back-to-back alternating single-cycle requests
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) begin
                ifu_req  = 1'b1;
                ifu_addr = 32'(4 * i);
            end else begin
                lsu_req   = 1'b1;
                lsu_we    = (i == 3);
                lsu_addr  = 32'(4 * i + 32'h40);
                lsu_wdata = 32'h5A5A_0000 | 32'(i);
                lsu_wstrb = 4'b1111;
            end
            step();
        end
        idle();
        repeat (2) step();
        lsu_op(1'b0, 32'h4C, 32'h0, 4'b0000);
        #2 check("b2b_write_read", lsu_rdata, 32'h5A5A_0003);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nnrv_mem_arb.md
Name: nnrv_mem_arb

Overview:
Arbiter that shares the single-port synchronous RAM inside nnrv_top between the instruction-fetch requester (IFU) and the load/store requester (LSU). Grants at most one access per cycle and routes the one-cycle-latency read data back to its owner. Uses fixed LSU priority with a starvation guard for the IFU. Flags accesses outside the RAM's address range and blocks them from the RAM.

Parameters:
RAM_AW, 10, RAM word-address width (RAM depth = 2**RAM_AW 32-bit words)
STARVE_MAX, 4, number of consecutive denied IFU cycles after which the IFU wins the next arbitration
BASE_ADDR, 32'h0000_0000, byte address that maps to RAM word 0

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_ifu_req  in  1  IFU read request
i_ifu_addr  in  32  IFU byte address
o_ifu_gnt  out  1  IFU request accepted this cycle
o_ifu_rvalid  out  1  IFU response valid
o_ifu_rdata  out  32  IFU read data
o_ifu_err  out  1  IFU response is an out-of-range error (qualified by o_ifu_rvalid)
i_lsu_req  in  1  LSU request
i_lsu_we  in  1  LSU write (1) or read (0)
i_lsu_addr  in  32  LSU byte address
i_lsu_wdata  in  32  LSU write data
i_lsu_wstrb  in  4  LSU byte-write strobes
o_lsu_gnt  out  1  LSU request accepted this cycle
o_lsu_rvalid  out  1  LSU response valid (issued for reads and writes)
o_lsu_rdata  out  32  LSU read data (0 for writes and errors)
o_lsu_err  out  1  LSU response is an out-of-range error
o_ram_en  out  1  RAM access enable
o_ram_we  out  4  RAM byte write enables
o_ram_addr  out  RAM_AW  RAM word address
o_ram_wdata  out  32  RAM write data
i_ram_rdata  in  32  RAM read data, valid one cycle after o_ram_en

Behaviour:
- Reset: all rvalid, err, and gnt outputs are 0, o_ram_en = 0, o_ram_we = 0, starve counter = 0, response tag cleared. Reset mid-transaction drops the outstanding response; no rvalid follows.
- Grants are combinational in the request cycle. Requesters hold req, addr, and data stable until gnt is seen.
- Arbitration when both requests are present: the LSU wins unless starve_cnt == STARVE_MAX, in which case the IFU wins.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each cycle where i_ifu_req = 1 and o_ifu_gnt = 0.
  - Clears whenever the IFU is granted or i_ifu_req = 0.
- Address decode: word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored. The access is in range iff (addr - BASE_ADDR) < 4 * 2**RAM_AW, computed with 33-bit unsigned arithmetic.
- Granted in-range access:
  - o_ram_en = 1 and o_ram_addr = word index.
  - o_ram_we = i_lsu_wstrb when the LSU is granted with i_lsu_we = 1; otherwise 0.
  - o_ram_wdata = i_lsu_wdata.
- Granted out-of-range access: o_ram_en = 0, but the grant still occurs.
- Response, registered with a {owner, is_err, is_write} tag:
  - Exactly one rvalid pulse to the owner in the cycle after the grant.
  - rdata = i_ram_rdata for in-range reads; 0 for writes and errors.
  - err = is_err.
  - The other requester's rvalid stays 0.
- Throughput: one grant per cycle, back-to-back. A new grant may issue in the same cycle a previous response is returned.
- No grant when there is no request. The RAM sees o_ram_en = 0 and o_ram_we = 0 on idle cycles.
- Write strobe of 4'b0000 with we = 1: treated as a write with no bytes changed; a response is still issued.

Decomposition:
- Shared package nnrv_mem_pkg holds:
  - owner encoding constants (OWN_IFU = 1'b0, OWN_LSU = 1'b1)
  - the response-tag struct/field widths
  - RAM_AW and BASE_ADDR defaults for reuse by nnrv_top and the RAM.
- One natural sub-module: nnrv_mem_arb_starve, containing the saturating starve counter and the priority-select logic. The arbiter top keeps decode, muxing, and the response register.

Test Plan:
- Solo IFU read: preload RAM[3] = 32'hDEADBEEF; IFU req, addr 0x0C -> gnt in the same cycle; next cycle o_ifu_rvalid = 1, rdata = DEADBEEF, err = 0; LSU outputs stay 0.
- LSU write then read: write addr 0x10, wdata 0x11223344, wstrb 4'b0011 over prior 0xAABBCCDD -> o_ram_we = 0011, and the write response has rdata = 0; read of 0x10 returns 0xAABB3344.
- Contention and starvation: both requests held continuously -> LSU is granted in cycles 0-3, IFU in cycle 4, then LSU in cycles 5-8 and IFU in cycle 9 (STARVE_MAX = 4); each response routes to the correct owner.
- Out of range: LSU read at 0x1000 with RAM_AW = 10 -> gnt = 1, o_ram_en = 0, next cycle o_lsu_rvalid = 1, err = 1, rdata = 0; address 0x0FFC is in range.
- Reset mid-operation: i_rst asserted in the cycle of an IFU grant -> no o_ifu_rvalid in the following cycle, starve counter = 0, and normal operation resumes after i_rst deasserts.
- Back-to-back: alternating single-cycle requests from IFU and LSU for 8 cycles -> 8 grants and 8 responses, each exactly one cycle after its grant, with no gaps.
